// File: rtl/rvvi_tx_arbiter.sv
// rtl/rvvi_tx_arbiter.sv - frame-atomic priority/round-robin arbiter onto the MAC tx AXI-stream
module rvvi_tx_arbiter #(
  parameter int NUM_SRC    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int IFG_CYCLES = 2,
  parameter int MAX_BEATS  = 512
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]   SrcTdata,
  input  logic [NUM_SRC*DATA_WIDTH/8-1:0] SrcTkeep,
  input  logic [NUM_SRC-1:0]              SrcTvalid,
  input  logic [NUM_SRC-1:0]              SrcTlast,
  output logic [NUM_SRC-1:0]              SrcTready,
  input  logic                            PrioSrc0,
  output logic [DATA_WIDTH-1:0]           MTdata,
  output logic [DATA_WIDTH/8-1:0]         MTkeep,
  output logic                            MTvalid,
  output logic                            MTlast,
  input  logic                            MTready,
  output logic [NUM_SRC-1:0]              Grant,
  output logic                            Busy,
  output logic                            TruncErr
);

  localparam int KW = DATA_WIDTH / 8;
  localparam int IW = $clog2(NUM_SRC);
  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam int GW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [CW-1:0] BEAT_LAST = CW'(MAX_BEATS - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
  localparam logic [IW-1:0] SRC_LAST  = IW'(NUM_SRC - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_GAP} state_e;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  // Round-robin pointer; between grant and frame end it also names the owner.
  logic [IW-1:0]      owner_q, owner_d;
  logic [CW-1:0]      beat_cnt_q, beat_cnt_d;
  logic [GW-1:0]      gap_cnt_q, gap_cnt_d;
  logic               trunc_err_q, trunc_err_d;

  logic [IW-1:0]         winner;
  logic [IW-1:0]         cand;
  logic [DATA_WIDTH-1:0] g_data;
  logic [KW-1:0]         g_keep;
  logic                  g_valid;
  logic                  g_last;
  logic                  beat;
  logic                  at_limit;

  // Pick the next owner: src 0 under strict priority, else first valid after the pointer.
  always_comb begin
    winner = '0;
    cand   = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      cand = IW'((int'(owner_q) + k) % NUM_SRC);
      if (SrcTvalid[cand]) winner = cand;
    end
    if (PrioSrc0 && SrcTvalid[0]) winner = '0;
  end

  // Select the owning source's stream signals.
  always_comb begin
    g_data  = '0;
    g_keep  = '0;
    g_valid = 1'b0;
    g_last  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (owner_q == IW'(i)) begin
        g_data  = SrcTdata[i*DATA_WIDTH +: DATA_WIDTH];
        g_keep  = SrcTkeep[i*KW +: KW];
        g_valid = SrcTvalid[i];
        g_last  = SrcTlast[i];
      end
    end
  end

  assign beat     = (state_q == S_STREAM) && g_valid && MTready;
  assign at_limit = (beat_cnt_q == BEAT_LAST);

  // State and bookkeeping registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      owner_q     <= SRC_LAST;
      beat_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      trunc_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      beat_cnt_q  <= beat_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      trunc_err_q <= trunc_err_d;
    end
  end

  // Next-state: arbitrate in IDLE, count beats, truncate runaway frames, time the gap.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    beat_cnt_d  = beat_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    trunc_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|SrcTvalid) begin
          state_d    = S_STREAM;
          owner_d    = winner;
          grant_d    = NUM_SRC'(1) << winner;
          beat_cnt_d = '0;
        end
      end
      S_STREAM: begin
        if (beat) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (g_last) begin
            state_d   = (IFG_CYCLES > 0) ? S_GAP : S_IDLE;
            grant_d   = '0;
            gap_cnt_d = '0;
          end else if (at_limit) begin
            state_d     = S_DRAIN;
            trunc_err_d = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (g_valid && g_last) begin
          state_d   = (IFG_CYCLES > 0) ? S_GAP : S_IDLE;
          grant_d   = '0;
          gap_cnt_d = '0;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = S_IDLE;
        else gap_cnt_d = gap_cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: pass the owner through while streaming, swallow its beats while draining.
  always_comb begin
    MTdata    = '0;
    MTkeep    = '0;
    MTvalid   = 1'b0;
    MTlast    = 1'b0;
    SrcTready = '0;
    case (state_q)
      S_STREAM: begin
        MTdata    = g_data;
        MTkeep    = g_keep;
        MTvalid   = g_valid;
        MTlast    = g_valid && (g_last || at_limit);
        SrcTready = grant_q & {NUM_SRC{MTready}};
      end
      S_DRAIN: SrcTready = grant_q;
      default: ;
    endcase
  end

  assign Grant    = grant_q;
  assign Busy     = (state_q != S_IDLE);
  assign TruncErr = trunc_err_q;

endmodule
